// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: splits each 32-bit load/store into two 16-bit SRAM accesses and holds the pipeline via ready.
// Optional one-entry read-hit tag enabled with `define SRAM_CTRL_READ_HIT_EN.
module mem_stage_sram_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 2,
    parameter int          SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int              CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic               op_wr;
    logic [SRAM_AW-2:0] word_q;
    logic [31:0]        wdata_q;

    logic [31:0]        offset;
    logic [SRAM_AW-2:0] req_word;
    logic               req;
    logic               hit;
    logic               unused_offset_bits;

    // Out-of-window addresses simply wrap; the byte lane bits are dropped.
    assign offset             = address - BASE_ADDR;
    assign req_word           = offset[SRAM_AW:2];
    assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};
    assign req                = rd_en | wr_en;

`ifdef SRAM_CTRL_READ_HIT_EN
    logic [SRAM_AW-2:0] tag_word;
    logic               tag_vld;

    assign hit = rd_en & ~wr_en & tag_vld & (tag_word == req_word);

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld  <= 1'b0;
            tag_word <= '0;
        end else if (state == S_IDLE && wr_en) begin
            tag_vld <= 1'b0;
        end else if (state == S_HIGH && cnt == LAST && !op_wr) begin
            tag_vld  <= 1'b1;
            tag_word <= word_q;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        ready = 1'b0;
        case (state)
            S_IDLE:  ready = ~req | hit;
            S_DONE:  ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op_wr       <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    // Write takes priority when both strobes are set.
                    if (req && !hit) begin
                        state       <= S_LOW;
                        cnt         <= '0;
                        op_wr       <= wr_en;
                        word_q      <= req_word;
                        wdata_q     <= write_data;
                        sram_addr   <= {req_word, 1'b0};
                        sram_dq_out <= write_data[15:0];
                        sram_dq_oe  <= wr_en;
                        sram_we_n   <= ~wr_en;
                    end
                end
                S_LOW: begin
                    if (cnt == LAST) begin
                        if (!op_wr) read_data[15:0] <= sram_dq_in;
                        state       <= S_HIGH;
                        cnt         <= '0;
                        sram_addr   <= {word_q, 1'b1};
                        sram_dq_out <= wdata_q[31:16];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (cnt == LAST) begin
                        if (!op_wr) read_data[31:16] <= sram_dq_in;
                        state      <= S_DONE;
                        cnt        <= '0;
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with an asynchronous 16-entry SRAM model.
module tb_mem_stage_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    logic [15:0] mem [16];

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mem_stage_sram_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n)
    );

    assign sram_dq_in = mem[sram_addr[3:0]];

    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) mem[sram_addr[3:0]] <= sram_dq_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // Counts ready-low cycles from the request cycle until DONE (bounded).
    task automatic count_busy(output int n);
        n = 0;
        while (!ready && n < 20) begin
            n++;
            tick();
        end
    endtask

    initial begin
        logic [11:0] pattern;
        int          n;

        for (int i = 0; i < 16; i++) mem[i] = 16'h0;
        rst        = 1'b1;
        rd_en      = 1'b1;
        wr_en      = 1'b0;
        address    = 32'd1028;
        write_data = 32'h0;

        // Reset with a read request pending
        tick();
        tick();
        check("rst_read_data", read_data, 32'h0);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        rst   = 1'b0;
        rd_en = 1'b0;
        #1;
        check("rst_ready", 32'(ready), 32'd1);

        // Write 0xDEADBEEF to byte address 1028
        wr_en      = 1'b1;
        address    = 32'd1028;
        write_data = 32'hDEADBEEF;
        #1;
        check("wr_ready_req", 32'(ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wr_ready_busy", 32'(ready), 32'd0);
            check("wr_we_n", 32'(sram_we_n), 32'd0);
            check("wr_oe", 32'(sram_dq_oe), 32'd1);
            check("wr_addr", 32'(sram_addr), (i < 2) ? 32'd2 : 32'd3);
            check("wr_dq", 32'(sram_dq_out), (i < 2) ? 32'h0000BEEF : 32'h0000DEAD);
        end
        tick();
        check("wr_done_ready", 32'(ready), 32'd1);
        check("wr_done_we_n", 32'(sram_we_n), 32'd1);
        check("wr_done_oe", 32'(sram_dq_oe), 32'd0);
        check("wr_read_data_untouched", read_data, 32'h0);
        wr_en = 1'b0;
        tick();
        check("wr_idle_ready", 32'(ready), 32'd1);

        // Read it back
        rd_en   = 1'b1;
        address = 32'd1028;
        #1;
        check("rd_ready_req", 32'(ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rd_ready_busy", 32'(ready), 32'd0);
            check("rd_we_n", 32'(sram_we_n), 32'd1);
            check("rd_oe", 32'(sram_dq_oe), 32'd0);
            check("rd_addr", 32'(sram_addr), (i < 2) ? 32'd2 : 32'd3);
        end
        tick();
        check("rd_done_ready", 32'(ready), 32'd1);
        check("rd_done_data", read_data, 32'hDEADBEEF);
        rd_en = 1'b0;
        tick();
        check("rd_data_held", read_data, 32'hDEADBEEF);

        // Simultaneous read and write: write wins
        rd_en      = 1'b1;
        wr_en      = 1'b1;
        address    = 32'd1024;
        write_data = 32'h12345678;
        #1;
        check("both_ready_req", 32'(ready), 32'd0);
        tick();
        check("both_we_n", 32'(sram_we_n), 32'd0);
        check("both_addr_lo", 32'(sram_addr), 32'd0);
        count_busy(n);
        check("both_busy_len", 32'(n), 32'd4);
        rd_en = 1'b0;
        wr_en = 1'b0;
        tick();
        check("both_read_data_unchanged", read_data, 32'hDEADBEEF);
        check("both_mem_lo", 32'(mem[0]), 32'h5678);
        check("both_mem_hi", 32'(mem[1]), 32'h1234);

        // Back-to-back reads, request held through DONE
        rd_en   = 1'b1;
        address = 32'd1024;
        #1;
        pattern = '0;
        for (int i = 0; i < 12; i++) begin
            pattern[i] = ready;
            if (i == 5) begin
                check("b2b_first_data", read_data, 32'h12345678);
                address = 32'd1028;
            end
            if (i == 11) begin
                check("b2b_second_data", read_data, 32'hDEADBEEF);
                rd_en = 1'b0;
            end
            tick();
        end
        check("b2b_ready_pattern", 32'(pattern), 32'h820);

        // Reset during the high half of a write
        wr_en      = 1'b1;
        address    = 32'd1032;
        write_data = 32'hAAAA5555;
        #1;
        tick();
        tick();
        tick();
        check("midrst_in_high_we_n", 32'(sram_we_n), 32'd0);
        check("midrst_in_high_addr", 32'(sram_addr), 32'd5);
        rst   = 1'b1;
        wr_en = 1'b0;
        tick();
        check("midrst_we_n", 32'(sram_we_n), 32'd1);
        check("midrst_oe", 32'(sram_dq_oe), 32'd0);
        check("midrst_read_data", read_data, 32'h0);
        check("midrst_addr", 32'(sram_addr), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_ready", 32'(ready), 32'd1);

`ifdef SRAM_CTRL_READ_HIT_EN
        rd_en   = 1'b1;
        address = 32'd1028;
        #1;
        count_busy(n);
        check("hit_first_miss_len", 32'(n), 32'd5);
        check("hit_first_data", read_data, 32'hDEADBEEF);
        rd_en = 1'b0;
        tick();
        rd_en = 1'b1;
        #1;
        check("hit_ready_comb", 32'(ready), 32'd1);
        tick();
        check("hit_ready_next", 32'(ready), 32'd1);
        check("hit_no_we", 32'(sram_we_n), 32'd1);
        check("hit_no_oe", 32'(sram_dq_oe), 32'd0);
        check("hit_data", read_data, 32'hDEADBEEF);
        rd_en      = 1'b0;
        wr_en      = 1'b1;
        write_data = 32'hDEADBEEF;
        #1;
        count_busy(n);
        check("hit_write_len", 32'(n), 32'd5);
        wr_en = 1'b0;
        tick();
        rd_en = 1'b1;
        #1;
        count_busy(n);
        check("hit_after_write_len", 32'(n), 32'd5);
        rd_en = 1'b0;
        tick();
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
